ca_grid_engine: RTL and testbench
=================================

# ca_grid_engine

Parametrised, time-multiplexed cellular-automaton engine that replaces the fully parallel per-cell Game of Life array with a row-sequential update of a ROWS×COLS grid. It supports configurable outer-totalistic rules, torus or dead-border edges, a load/step handshake, generation counting, and population, stable and extinct status. It sits between the generation-rate divider, which drives `step`, and the VGA renderer and LEDs, which read `state`.

## Interface
- COLS, 16, grid width in cells (≥3)
- ROWS, 16, grid height in cells (≥3)
- WRAP, 1, 1 = toroidal edges; 0 = cells outside the grid count as dead
- BIRTH_MASK, 9'b000001000, bit n set → dead cell with n live neighbours is born (default B3)
- SURVIVE_MASK, 9'b000001100, bit n set → live cell with n live neighbours survives (default S23)
- GEN_W, 16, width of the generation counter
- clk_in  input  1  system clock
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low
- load  input  1  sampled in IDLE; copies `init_state` into the grid
- step  input  1  sampled in IDLE; computes one generation
- init_state  input  ROWS*COLS  seed pattern; cell (r,c) is bit r*COLS+c
- state  output  ROWS*COLS  current generation, same indexing
- busy  output  1  high while a step is in progress
- done  output  1  one-cycle pulse when a step commits
- generation  output  GEN_W  steps committed since the last load or reset
- population  output  clog2(ROWS*COLS+1)  live-cell count of `state`
- stable  output  1  last committed step left `state` unchanged
- extinct  output  1  population == 0

## Operation
- FSM states are IDLE, CALC and COMMIT. `busy` = (FSM ≠ IDLE).
- In IDLE:
  - `load` has priority over `step` when both are high.
  - `load` sets: state ← init_state; generation ← 0; population ← popcount(init_state); stable ← 0; extinct ← (popcount == 0).
  - `step` moves the FSM to CALC, with row counter ← 0 and the population accumulator ← 0.
- While busy, `load` and `step` are ignored and not queued.
- CALC processes one row per cycle, for row = 0..ROWS-1:
  - Neighbour count n (4 bits, 0..8) of each cell in the row is read from `state`. `state` is unmodified during CALC.
  - Next value = alive ? SURVIVE_MASK[n] : BIRTH_MASK[n].
  - The result is written to row `row` of a shadow register, and the row's popcount is added to the accumulator.
  - After row ROWS-1 the FSM goes to COMMIT.
- Neighbour indexing:
  - WRAP=1: row±1 mod ROWS, col±1 mod COLS.
  - WRAP=0: any out-of-range neighbour contributes 0.
- COMMIT (one cycle):
  - stable ← (shadow == state); state ← shadow; population ← accumulator; extinct ← (accumulator == 0).
  - generation ← generation+1, wrapping from 2^GEN_W−1 to 0.
  - `done` pulses; the FSM returns to IDLE.
- Reset values: state=0, generation=0, population=0, busy=0, done=0, stable=0, extinct=1, FSM=IDLE, shadow=0.
- Reset asserted mid-CALC clears everything immediately and discards the partial shadow.

## Timing
- `step` sampled high in IDLE at edge E0:
  - busy=1 from E0 to E0+ROWS+1.
  - CALC occupies edges E0+1..E0+ROWS.
  - At edge E0+ROWS+1: state, generation, population, stable and extinct update, done=1 and busy=0.
  - At edge E0+ROWS+2: done=0.
- Step latency is ROWS+1 cycles. Maximum step rate is one per ROWS+2 cycles: a `step` held high restarts at the first IDLE edge.
- `load`: all outputs update at the sampling edge (latency 1); done stays 0.
- All outputs are registered; there is no combinational input→output path.

## Test plan
- Reset, then load a horizontal blinker at (5,4),(5,5),(5,6) on a 16×16 grid and step. Required: done exactly 17 cycles after step; cells (4,5),(5,5),(6,5) set; population=3; generation=1; stable=0. A second step restores the original pattern with generation=2.
- Load a block at (2,2),(2,3),(3,2),(3,3) and step. Required: state unchanged, stable=1, population=4, extinct=0.
- Corner cells (0,0),(0,15),(15,0), stepped once:
  - WRAP=1: (15,15) is born, population=4, stable=0; a second step gives stable=1.
  - WRAP=0: population=0, extinct=1.
- Load a glider on the WRAP=1 torus and issue 64 steps. Required: state equals the loaded pattern, generation=64, population=5 after every step.
- Set BIRTH_MASK=9'b000000100 and SURVIVE_MASK=0 (Seeds), load (5,5),(5,6) and step. Required: exactly (4,5),(4,6),(6,5),(6,6) set; population=4.
- Handshake and reset checks:
  - `step` pulsed at cycle 3 of CALC: ignored, generation increments by 1 only.
  - `load`+`step` in the same IDLE cycle: load wins, busy stays 0.
  - rst_n dropped during CALC: all outputs return to their reset values with no clock edge required.

Source files
------------

// File: rtl/ca_grid_if.sv
// ca_grid_if: load/step handshake and grid status bundle between the rate divider/renderer side and ca_grid_engine
// master: drives load, step, init_state; slave: drives state, busy, done, generation, population, stable, extinct
interface ca_grid_if #(
  parameter int ROWS  = 16,
  parameter int COLS  = 16,
  parameter int GEN_W = 16
);
  localparam int N  = ROWS * COLS;
  localparam int PW = $clog2(N + 1);
  logic             load;
  logic             step;
  logic [N-1:0]     init_state;
  logic [N-1:0]     state;
  logic             busy;
  logic             done;
  logic [GEN_W-1:0] generation;
  logic [PW-1:0]    population;
  logic             stable;
  logic             extinct;
  modport master (
    output load, step, init_state,
    input  state, busy, done, generation, population, stable, extinct
  );
  modport slave (
    input  load, step, init_state,
    output state, busy, done, generation, population, stable, extinct
  );
endinterface

// File: rtl/ca_grid_engine.sv
// ca_grid_engine: row-sequential outer-totalistic cellular automaton on a ROWS x COLS grid
// clk_in/rst_n: clock and async active-low reset; bus (slave): load/step/init_state in,
// state/busy/done/generation/population/stable/extinct out, all registered
module ca_grid_engine #(
  parameter int         COLS         = 16,
  parameter int         ROWS         = 16,
  parameter bit         WRAP         = 1'b1,
  parameter logic [8:0] BIRTH_MASK   = 9'b000001000,
  parameter logic [8:0] SURVIVE_MASK = 9'b000001100,
  parameter int         GEN_W        = 16
) (
  input logic     clk_in,
  input logic     rst_n,
  ca_grid_if.slave bus
);
  localparam int N  = ROWS * COLS;
  localparam int PW = $clog2(N + 1);
  localparam int RW = $clog2(ROWS);
  typedef enum logic [1:0] {IDLE, CALC, COMMIT} fsm_t;
  fsm_t            fsm;
  logic [RW-1:0]   row;
  logic [RW-1:0]   up_i;
  logic [RW-1:0]   dn_i;
  logic [N-1:0]    shadow;
  logic [PW-1:0]   acc;
  logic [COLS-1:0] r_up;
  logic [COLS-1:0] r_mid;
  logic [COLS-1:0] r_dn;
  logic [COLS-1:0] nxt;
  // the three rows around the current row; off-grid rows read as dead without wrap
  always_comb begin
    up_i  = row == '0 ? RW'(ROWS - 1) : row - 1'b1;
    dn_i  = row == RW'(ROWS - 1) ? '0 : row + 1'b1;
    r_up  = (WRAP || row != '0) ? bus.state[up_i*COLS +: COLS] : '0;
    r_mid = bus.state[row*COLS +: COLS];
    r_dn  = (WRAP || row != RW'(ROWS - 1)) ? bus.state[dn_i*COLS +: COLS] : '0;
  end
  for (genvar c = 0; c < COLS; c++) begin : g_col
    localparam int L  = c == 0 ? COLS - 1 : c - 1;
    localparam int R  = c == COLS - 1 ? 0 : c + 1;
    localparam bit LV = WRAP || c != 0;
    localparam bit RV = WRAP || c != COLS - 1;
    logic [3:0] n;
    assign n = 4'(r_up[c]) + 4'(r_dn[c])
             + 4'(LV & r_up[L]) + 4'(LV & r_mid[L]) + 4'(LV & r_dn[L])
             + 4'(RV & r_up[R]) + 4'(RV & r_mid[R]) + 4'(RV & r_dn[R]);
    assign nxt[c] = r_mid[c] ? SURVIVE_MASK[n] : BIRTH_MASK[n];
  end
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      fsm            <= IDLE;
      row            <= '0;
      shadow         <= '0;
      acc            <= '0;
      bus.state      <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.generation <= '0;
      bus.population <= '0;
      bus.stable     <= 1'b0;
      bus.extinct    <= 1'b1;
    end else begin
      bus.done <= 1'b0;
      case (fsm)
        IDLE: begin
          if (bus.load) begin
            bus.state      <= bus.init_state;
            bus.generation <= '0;
            bus.population <= PW'($countones(bus.init_state));
            bus.stable     <= 1'b0;
            bus.extinct    <= bus.init_state == '0;
          end else if (bus.step) begin
            fsm      <= CALC;
            bus.busy <= 1'b1;
            row      <= '0;
            acc      <= '0;
          end
        end
        CALC: begin
          shadow[row*COLS +: COLS] <= nxt;
          acc <= acc + PW'($countones(nxt));
          row <= row + 1'b1;
          if (row == RW'(ROWS - 1)) fsm <= COMMIT;
        end
        COMMIT: begin
          bus.stable     <= shadow == bus.state;
          bus.state      <= shadow;
          bus.population <= acc;
          bus.extinct    <= acc == '0;
          bus.generation <= bus.generation + 1'b1;
          bus.done       <= 1'b1;
          bus.busy       <= 1'b0;
          fsm            <= IDLE;
        end
        default: fsm <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ca_grid_engine.sv
// tb_ca_grid_engine: directed scoreboard bench for ca_grid_engine (torus, dead-border and Seeds variants)
module tb_ca_grid_engine;
  typedef struct {
    logic [255:0] st;
    bit           cs;
    logic [15:0]  gen;
    logic [8:0]   pop;
    logic         stb;
    logic         ext;
    int           dc;
  } exp_t;
  logic clk_in = 1'b0;
  logic rst_n = 1'b0;
  logic ld = 1'b0;
  logic [255:0] init = '0;
  logic [2:0] stp = '0;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ndone[3] = '{0, 0, 0};
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;
  ca_grid_if b0 ();
  ca_grid_if b1 ();
  ca_grid_if b2 ();
  assign b0.load = ld;
  assign b1.load = ld;
  assign b2.load = ld;
  assign b0.init_state = init;
  assign b1.init_state = init;
  assign b2.init_state = init;
  assign b0.step = stp[0];
  assign b1.step = stp[1];
  assign b2.step = stp[2];
  ca_grid_engine u0 (.clk_in(clk_in), .rst_n(rst_n), .bus(b0));
  ca_grid_engine #(.WRAP(1'b0)) u1 (.clk_in(clk_in), .rst_n(rst_n), .bus(b1));
  ca_grid_engine #(.BIRTH_MASK(9'b000000100), .SURVIVE_MASK(9'b000000000)) u2 (.clk_in(clk_in), .rst_n(rst_n), .bus(b2));

  function automatic logic [255:0] cl(input int r, input int c);
    logic [255:0] one = 256'(1);
    return one << (r * 16 + c);
  endfunction

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, got, want);
    end
  endtask

  task automatic mon(input int id, input logic [255:0] st, input logic [15:0] g, input logic [8:0] p,
                     input logic sb, input logic ex, input logic bz);
    exp_t e;
    int sz;
    sz = id == 0 ? q0.size() : id == 1 ? q1.size() : q2.size();
    ndone[id]++;
    if (sz == 0) begin
      total++;
      bad++;
      $display("FAIL dut%0d_unexpected_done: got done with generation=%0d want no done", id, g);
    end else begin
      if (id == 0) e = q0.pop_front();
      else if (id == 1) e = q1.pop_front();
      else e = q2.pop_front();
      if (e.cs) chk($sformatf("dut%0d_state", id), st, e.st);
      chk($sformatf("dut%0d_generation", id), g, e.gen);
      chk($sformatf("dut%0d_population", id), p, e.pop);
      chk($sformatf("dut%0d_stable", id), sb, e.stb);
      chk($sformatf("dut%0d_extinct", id), ex, e.ext);
      chk($sformatf("dut%0d_busy_at_done", id), bz, 0);
      chk($sformatf("dut%0d_done_latency", id), cyc, e.dc);
    end
  endtask

  always @(negedge clk_in) begin
    if (b0.done) mon(0, b0.state, b0.generation, b0.population, b0.stable, b0.extinct, b0.busy);
    if (b1.done) mon(1, b1.state, b1.generation, b1.population, b1.stable, b1.extinct, b1.busy);
    if (b2.done) mon(2, b2.state, b2.generation, b2.population, b2.stable, b2.extinct, b2.busy);
  end

  // step is held across exactly one rising edge; done must appear ROWS+1 edges later
  task automatic do_step(input int id, input bit push, input bit wt, input logic [255:0] st, input bit cs,
                         input int g, input int p, input bit sb);
    exp_t e;
    int n0;
    @(negedge clk_in);
    stp[id] = 1'b1;
    e.st = st;
    e.cs = cs;
    e.gen = 16'(g);
    e.pop = 9'(p);
    e.stb = sb;
    e.ext = p == 0;
    e.dc = cyc + 18;
    if (push) begin
      if (id == 0) q0.push_back(e);
      else if (id == 1) q1.push_back(e);
      else q2.push_back(e);
    end
    n0 = ndone[id];
    @(negedge clk_in);
    stp[id] = 1'b0;
    if (wt) begin
      for (int k = 0; k < 40 && ndone[id] == n0; k++) @(negedge clk_in);
      chk($sformatf("dut%0d_done_seen", id), 256'(ndone[id] - n0), 1);
    end
  endtask

  task automatic do_load(input logic [255:0] p, input int pp);
    @(negedge clk_in);
    init = p;
    ld = 1'b1;
    @(negedge clk_in);
    ld = 1'b0;
    chk("load_state", b0.state, p);
    chk("load_generation", b0.generation, 0);
    chk("load_population", b0.population, 256'(pp));
    chk("load_stable", b0.stable, 0);
    chk("load_extinct", b0.extinct, pp == 0);
    chk("load_done", b0.done, 0);
    chk("load_busy", b0.busy, 0);
    chk("load_state_dut2", b2.state, p);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_state"}, b0.state, 0);
    chk({tag, "_generation"}, b0.generation, 0);
    chk({tag, "_population"}, b0.population, 0);
    chk({tag, "_busy"}, b0.busy, 0);
    chk({tag, "_done"}, b0.done, 0);
    chk({tag, "_stable"}, b0.stable, 0);
    chk({tag, "_extinct"}, b0.extinct, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [255:0] blink_h, blink_v, block, corners, glider, seeds_in, seeds_out;
    blink_h = cl(5, 4) | cl(5, 5) | cl(5, 6);
    blink_v = cl(4, 5) | cl(5, 5) | cl(6, 5);
    block = cl(2, 2) | cl(2, 3) | cl(3, 2) | cl(3, 3);
    corners = cl(0, 0) | cl(0, 15) | cl(15, 0);
    glider = cl(1, 2) | cl(2, 3) | cl(3, 1) | cl(3, 2) | cl(3, 3);
    seeds_in = cl(5, 5) | cl(5, 6);
    seeds_out = cl(4, 5) | cl(4, 6) | cl(6, 5) | cl(6, 6);
    repeat (3) @(negedge clk_in);
    chk_reset("reset");
    rst_n = 1'b1;
    do_load(blink_h, 3);
    do_step(0, 1, 1, blink_v, 1, 1, 3, 0);
    do_step(0, 1, 1, blink_h, 1, 2, 3, 0);
    do_load(block, 4);
    do_step(0, 1, 1, block, 1, 1, 4, 1);
    do_load(corners, 3);
    do_step(0, 1, 1, corners | cl(15, 15), 1, 1, 4, 0);
    do_step(1, 1, 1, '0, 1, 1, 0, 0);
    do_step(0, 1, 1, corners | cl(15, 15), 1, 2, 4, 1);
    do_load(glider, 5);
    for (int s = 1; s <= 64; s++) do_step(0, 1, 1, glider, s == 64, s, 5, 0);
    do_load(seeds_in, 2);
    do_step(2, 1, 1, seeds_out, 1, 1, 4, 0);
    do_load(blink_h, 3);
    do_step(0, 1, 0, blink_v, 1, 1, 3, 0);
    repeat (2) @(negedge clk_in);
    stp[0] = 1'b1;
    @(negedge clk_in);
    stp[0] = 1'b0;
    for (int k = 0; k < 40 && b0.generation == 16'd0; k++) @(negedge clk_in);
    repeat (40) @(negedge clk_in);
    chk("ignored_step_generation", b0.generation, 1);
    @(negedge clk_in);
    init = block;
    ld = 1'b1;
    stp[0] = 1'b1;
    @(negedge clk_in);
    ld = 1'b0;
    stp[0] = 1'b0;
    chk("load_step_busy", b0.busy, 0);
    chk("load_step_state", b0.state, block);
    chk("load_step_generation", b0.generation, 0);
    @(negedge clk_in);
    chk("load_step_busy_later", b0.busy, 0);
    do_step(0, 0, 0, '0, 0, 0, 0, 0);
    repeat (4) @(negedge clk_in);
    chk("calc_busy_before_reset", b0.busy, 1);
    #2 rst_n = 1'b0;
    #1 chk_reset("async_reset");
    @(negedge clk_in);
    rst_n = 1'b1;
    repeat (30) @(negedge clk_in);
    chk("post_reset_generation", b0.generation, 0);
    chk("queue_left", 256'(q0.size() + q1.size() + q2.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
